// File: rtl/hqc_ct_pkg.sv
// ----------------------------------------------------------------------------
// hqc_ct_pkg : shared parameter lookups and encodings for the HQC ct loader
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hqc_ct_pkg;

  localparam int RAMWIDTH = 128;
  localparam int D_BYTES  = 64;

  localparam logic [1:0] CT_SEL_U = 2'd0;
  localparam logic [1:0] CT_SEL_V = 2'd1;
  localparam logic [1:0] CT_SEL_D = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_U = 3'd1,
    S_LOAD_V = 3'd2,
    S_LOAD_D = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  function automatic int ct_n(input logic [47:0] ps);
    int r;
    r = 17669;
    if (ps == "hqc192") r = 35851;
    if (ps == "hqc256") r = 57637;
    return r;
  endfunction

  function automatic int ct_n1n2(input logic [47:0] ps);
    int r;
    r = 17664;
    if (ps == "hqc192") r = 35840;
    if (ps == "hqc256") r = 57600;
    return r;
  endfunction

  function automatic int ct_u_bytes(input logic [47:0] ps);
    return (ct_n(ps) + 7) / 8;
  endfunction

  function automatic int ct_v_bytes(input logic [47:0] ps);
    return ct_n1n2(ps) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hqc_ct_packer.sv
// ----------------------------------------------------------------------------
// hqc_ct_packer : 32->128 byte-lane packer with flush-on-last and tail masking
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hqc_ct_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         beat,
  input  logic         last,
  input  logic [2:0]   last_keep,
  input  logic [7:0]   tail_keep,
  input  logic [31:0]  din,
  output logic         word_done,
  output logic [127:0] word,
  output logic         pad_bad
);

  logic [1:0]   lane;
  logic [127:0] acc;
  logic [31:0]  lane_bytes;
  logic [7:0]   b;

  // Stream byte k (din[31-8k -: 8]) lands in the low-order byte first of its lane.
  always_comb begin
    lane_bytes = '0;
    pad_bad    = 1'b0;
    b          = '0;
    for (int k = 0; k < 4; k++) begin
      b = din[31-8*k -: 8];
      if (last && (k >= int'(last_keep))) begin
        b = '0;
      end else if (last && (k == int'(last_keep) - 1)) begin
        pad_bad = beat && (|(b & ~tail_keep));
        b       = b & tail_keep;
      end
      lane_bytes[8*k +: 8] = b;
    end
    word                = acc;
    word[32*lane +: 32] = lane_bytes;
    word_done           = beat && ((lane == 2'd3) || last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (clear) begin
      lane <= '0;
      acc  <= '0;
    end else if (beat) begin
      if (word_done) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 2'd1;
        acc  <= word;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hqc_ct_loader.sv
// ----------------------------------------------------------------------------
// hqc_ct_loader : decap ciphertext ingest, 32-bit stream into u/v/d RAM words
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hqc_ct_loader
  import hqc_ct_pkg::*;
#(
  parameter logic [47:0] PARAMETER_SET = "hqc128",
  parameter int N       = ct_n(PARAMETER_SET),
  parameter int N1N2    = ct_n1n2(PARAMETER_SET),
  parameter int U_BYTES = (N + 7) / 8,
  parameter int V_BYTES = N1N2 / 8,
  parameter int ADDR_W  = $clog2((N + RAMWIDTH - 1) / RAMWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ct_wen,
  output logic [1:0]        ct_sel,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [127:0]      ct_wdata,
  output logic              busy,
  output logic              done,
  output logic              pad_err
);

  localparam int U_BEATS = (U_BYTES + 3) / 4;
  localparam int V_BEATS = (V_BYTES + 3) / 4;
  localparam int D_BEATS = (D_BYTES + 3) / 4;
  localparam int CNT_W   = $clog2(U_BEATS + 1);
  localparam logic [2:0] U_KEEP = 3'((U_BYTES - 1) % 4 + 1);
  localparam logic [2:0] V_KEEP = 3'((V_BYTES - 1) % 4 + 1);
  localparam logic [2:0] D_KEEP = 3'((D_BYTES - 1) % 4 + 1);
  localparam int N_REM = N % 8;
  localparam logic [7:0] U_TAIL = (N_REM == 0) ? 8'hFF : 8'((1 << N_REM) - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, sec_last;
  logic [ADDR_W-1:0] waddr;
  logic              beat, last, clear, done_nxt;
  logic [2:0]        last_keep;
  logic [7:0]        tail_keep;
  logic [1:0]        sel_cur;
  logic              word_done, pad_bad;
  logic [127:0]      word;

  assign din_ready = (state == S_LOAD_U) || (state == S_LOAD_V) || (state == S_LOAD_D);
  assign busy      = (state != S_IDLE);
  assign beat      = din_valid && din_ready;
  assign last      = beat && (cnt == sec_last);

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    done_nxt  = 1'b0;
    sec_last  = CNT_W'(U_BEATS - 1);
    last_keep = U_KEEP;
    tail_keep = 8'hFF;
    sel_cur   = CT_SEL_U;
    case (state)
      S_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_LOAD_U;
        end
      end
      S_LOAD_U: begin
        tail_keep = U_TAIL;
        if (last) state_nxt = S_LOAD_V;
      end
      S_LOAD_V: begin
        sec_last  = CNT_W'(V_BEATS - 1);
        last_keep = V_KEEP;
        sel_cur   = CT_SEL_V;
        if (last) state_nxt = S_LOAD_D;
      end
      S_LOAD_D: begin
        sec_last  = CNT_W'(D_BEATS - 1);
        last_keep = D_KEEP;
        sel_cur   = CT_SEL_D;
        if (last) state_nxt = S_FIN;
      end
      S_FIN: begin
        // ct_wen here is the final d flush issued from the last d beat
        if (ct_wen) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Write register is separate from the section state so a flush can carry
  // the old ct_sel while the next section already accepts beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      waddr    <= '0;
      ct_wen   <= 1'b0;
      ct_sel   <= CT_SEL_U;
      ct_addr  <= '0;
      ct_wdata <= '0;
      done     <= 1'b0;
      pad_err  <= 1'b0;
    end else begin
      done   <= done_nxt;
      ct_wen <= word_done;
      if (clear) begin
        cnt     <= '0;
        waddr   <= '0;
        pad_err <= 1'b0;
      end else if (beat) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (pad_bad) pad_err <= 1'b1;
      end
      if (word_done) begin
        ct_sel   <= sel_cur;
        ct_addr  <= waddr;
        ct_wdata <= word;
        waddr    <= last ? '0 : waddr + 1'b1;
      end
    end
  end

  hqc_ct_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .beat      (beat),
    .last      (last),
    .last_keep (last_keep),
    .tail_keep (tail_keep),
    .din       (din),
    .word_done (word_done),
    .word      (word),
    .pad_bad   (pad_bad)
  );

endmodule

`default_nettype wire

// File: tb/tb_hqc_ct_loader.sv
// ----------------------------------------------------------------------------
// tb_hqc_ct_loader : directed self-checking bench for hqc_ct_loader (hqc128)
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hqc_ct_loader;

  localparam int U_BYTES = 2209;
  localparam int V_BYTES = 2208;
  localparam int D_BYTES = 64;
  localparam int ADDR_W  = 8;
  localparam int NWORDS [0:2] = '{139, 138, 4};
  localparam int NBEATS [0:2] = '{553, 552, 16};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready, ct_wen, busy, done, pad_err;
  logic [1:0]        ct_sel;
  logic [ADDR_W-1:0] ct_addr;
  logic [127:0]      ct_wdata;

  hqc_ct_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ct_wen    (ct_wen),
    .ct_sel    (ct_sel),
    .ct_addr   (ct_addr),
    .ct_wdata  (ct_wdata),
    .busy      (busy),
    .done      (done),
    .pad_err   (pad_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Write monitor: builds RAM images and a write log, cleared on an accepted start.
  logic [127:0] img [0:2][0:255];
  int wr_cnt [0:2] = '{0, 0, 0};
  int seq_err = 0;
  int wr_n = 0;
  int done_n = 0;
  int done_cyc = -1;
  int log_sel [0:511];
  int log_addr [0:511];

  always @(negedge clk) begin
    if (start && !busy) begin
      wr_cnt   = '{0, 0, 0};
      seq_err  = 0;
      wr_n     = 0;
      done_n   = 0;
      done_cyc = -1;
    end
    if (ct_wen) begin
      if (ct_sel > 2'd2) begin
        seq_err++;
      end else begin
        if (int'(ct_addr) != wr_cnt[ct_sel]) seq_err++;
        if (wr_n > 0 && int'(ct_sel) < log_sel[wr_n-1]) seq_err++;
        img[ct_sel][ct_addr] = ct_wdata;
        wr_cnt[ct_sel]++;
      end
      if (wr_n < 512) begin
        log_sel[wr_n]  = int'(ct_sel);
        log_addr[wr_n] = int'(ct_addr);
      end
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  function automatic int sec_len(input int sec);
    return (sec == 0) ? U_BYTES : (sec == 1) ? V_BYTES : D_BYTES;
  endfunction

  function automatic logic [7:0] sbyte(input int sec, input int i, input logic [7:0] ulast);
    if (sec == 0 && i == U_BYTES - 1) return ulast;
    return 8'((i * 7 + sec * 61 + 3) & 255);
  endfunction

  function automatic logic [31:0] beat_word(input int sec, input int j, input logic [7:0] ulast);
    logic [31:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 4 * j + k;
      if (idx < sec_len(sec)) w[31-8*k -: 8] = sbyte(sec, idx, ulast);
      else                    w[31-8*k -: 8] = 8'(170 + 17 * (k - 1));
    end
    return w;
  endfunction

  // hqc128: N % 8 = 5, so only bits 4:0 of the last u byte survive.
  function automatic logic [127:0] exp_word(input int sec, input int a, input logic [7:0] ulast);
    logic [127:0] w;
    logic [7:0]   bb;
    int idx;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 16 * a + i;
      bb  = (idx < sec_len(sec)) ? sbyte(sec, idx, ulast) : 8'h00;
      if (sec == 0 && idx == U_BYTES - 1) bb = bb & 8'h1F;
      w[8*i +: 8] = bb;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int acc_cyc = 0;
  int to_err = 0;

  task automatic send(input logic [31:0] w, input bit gappy);
    bit acc;
    int guard;
    if (gappy) begin
      din_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    din = w;
    din_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = din_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
    end
    din_valid = 1'b0;
    if (!acc) to_err++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] ulast, input bit gappy, input int vstart_at);
    to_err = 0;
    pulse_start();
    chk("start_busy", 128'(busy), 128'd1);
    chk("start_pad_clear", 128'(pad_err), 128'd0);
    for (int sec = 0; sec < 3; sec++) begin
      for (int j = 0; j < NBEATS[sec]; j++) begin
        if (sec == 1 && j == vstart_at) start = 1'b1;
        send(beat_word(sec, j, ulast), gappy);
        start = 1'b0;
      end
    end
    for (int g = 0; g < 20 && done_n == 0; g++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_load(input string tag, input logic [7:0] ulast, input bit exp_pad);
    int bad;
    logic [127:0] first_obs, first_exp;
    chk({tag, "_timeouts"}, 128'(to_err), 128'd0);
    chk({tag, "_done_count"}, 128'(done_n), 128'd1);
    chk({tag, "_done_latency"}, 128'(done_cyc - acc_cyc), 128'd2);
    chk({tag, "_wr_u"}, 128'(wr_cnt[0]), 128'd139);
    chk({tag, "_wr_v"}, 128'(wr_cnt[1]), 128'd138);
    chk({tag, "_wr_d"}, 128'(wr_cnt[2]), 128'd4);
    chk({tag, "_wr_total"}, 128'(wr_n), 128'd281);
    chk({tag, "_addr_order"}, 128'(seq_err), 128'd0);
    chk({tag, "_u_flush"}, {64'(log_sel[138]), 64'(log_addr[138])}, {64'd0, 64'd138});
    chk({tag, "_v_first"}, {64'(log_sel[139]), 64'(log_addr[139])}, {64'd1, 64'd0});
    for (int sec = 0; sec < 3; sec++) begin
      bad = 0;
      first_obs = '0;
      first_exp = '0;
      for (int a = 0; a < NWORDS[sec]; a++) begin
        if (img[sec][a] !== exp_word(sec, a, ulast)) begin
          if (bad == 0) begin
            first_obs = img[sec][a];
            first_exp = exp_word(sec, a, ulast);
          end
          bad++;
        end
      end
      chk($sformatf("%s_image%0d_first_bad", tag, sec), first_obs, first_exp);
      chk($sformatf("%s_image%0d_bad_words", tag, sec), 128'(bad), 128'd0);
    end
    chk({tag, "_u_tail"}, img[0][138], 128'h1F);
    chk({tag, "_pad_err"}, 128'(pad_err), 128'(exp_pad));
    chk({tag, "_idle"}, {126'd0, busy, done}, 128'd0);
  endtask

  initial begin
    logic ready_seen;

    // reset and idle behaviour
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {din_ready, ct_wen, busy, done, pad_err, ct_sel, ct_addr}, 128'd0);
    chk("reset_wdata", ct_wdata, 128'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    din = 32'h1234_5678;
    din_valid = 1'b1;
    ready_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (din_ready) ready_seen = 1'b1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("idle_ready", 128'(ready_seen), 128'd0);
    chk("idle_writes", 128'(wr_n), 128'd0);

    // gapless load, clean tail byte
    run_load(8'h1F, 1'b0, -1);
    check_load("gapless", 8'h1F, 1'b0);

    // gappy load, dirty tail byte: masked to 0x1F and pad_err sticky
    run_load(8'hFF, 1'b1, -1);
    check_load("gappy_pad", 8'hFF, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    chk("pad_sticky", 128'(pad_err), 128'd1);

    // start during LOAD_V must be ignored; new start clears pad_err
    run_load(8'h1F, 1'b0, 10);
    check_load("start_in_v", 8'h1F, 1'b0);

    // reset mid-LOAD_U
    pulse_start();
    for (int j = 0; j < 100; j++) send(beat_word(0, j, 8'h1F), 1'b0);
    din_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", {din_ready, ct_wen, busy, done, pad_err, ct_sel, ct_addr}, 128'd0);
    chk("midreset_wdata", ct_wdata, 128'd0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_load(8'h1F, 1'b0, -1);
    check_load("after_reset", 8'h1F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
